edusoc_dbg_master: RTL and testbench

Debug bus initiator for the EduSoC data port. It receives a byte-oriented command stream, for example from a UART receiver. It then drives single-word read or write transactions on the DATA_* request/response interface that a CPU core normally drives, and returns a status byte plus read data as a byte stream. It sits on the CPU side of the EduSoC bus and lets a host load or peek memory and peripherals with no processor present.

---
 rtl/edusoc_dbg_master.sv | 206 ++++++++++++++++++++
 tb/tb_edusoc_dbg_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edusoc_dbg_master.sv
// Debug bus initiator: turns a host byte stream into single-word EduSoC data-port
// transactions and streams back a status byte plus any read data, LSB first.
module edusoc_dbg_master #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RES,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        DATA_REQ,
  input  logic        DATA_VALID,
  output logic        DATA_WE,
  output logic [3:0]  DATA_BE,
  output logic [31:0] DATA_ADDR,
  output logic [31:0] DATA_WDATA,
  input  logic [31:0] DATA_RDATA,
  output logic        BUSY
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ST_OK     = 8'h4B;
  localparam logic [7:0] ST_ERR    = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_STAT,
    S_RDATA
  } state_e;

  state_e           state_q, state_d;
  logic             is_write_q, is_write_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;

  logic             tx_accept;
  logic [1:0]       next_byte;
  logic             start_bus;
  logic             end_bus;
  logic [7:0]       end_status;

  assign tx_accept = tx_valid_q && TX_READY;
  assign next_byte = byte_cnt_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tmo_cnt_d  = tmo_cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    start_bus  = 1'b0;
    end_bus    = 1'b0;
    end_status = ST_ERR;

    unique case (state_q)
      S_IDLE: begin
        if (RX_VALID && (RX_DATA == CMD_WRITE || RX_DATA == CMD_READ)) begin
          is_write_d = (RX_DATA == CMD_WRITE);
          byte_cnt_d = 2'd0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (RX_VALID) begin
          addr_d[{byte_cnt_q, 3'b000} +: 8] = RX_DATA;
          byte_cnt_d = next_byte;
          if (byte_cnt_q == 2'd3) begin
            if (is_write_q) state_d = S_WDATA;
            else            start_bus = 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (RX_VALID) begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = RX_DATA;
          byte_cnt_d = next_byte;
          if (byte_cnt_q == 2'd3) start_bus = 1'b1;
        end
      end
      S_BUS: begin
        // A completion in the final allowed cycle still wins over the timeout.
        if (DATA_VALID) begin
          end_bus    = 1'b1;
          end_status = ST_OK;
          if (!is_write_q) rdata_d = DATA_RDATA;
        end else if (tmo_cnt_q == CNT_LAST) begin
          end_bus = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_STAT: begin
        if (tx_accept) begin
          if (!is_write_q && tx_data_q == ST_OK) begin
            state_d    = S_RDATA;
            byte_cnt_d = 2'd0;
            tx_data_d  = rdata_q[7:0];
          end else begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end
        end
      end
      S_RDATA: begin
        if (tx_accept) begin
          if (byte_cnt_q == 2'd3) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end else begin
            byte_cnt_d = next_byte;
            tx_data_d  = rdata_q[{next_byte, 3'b000} +: 8];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    addr_d[1:0] = 2'b00;

    if (start_bus) begin
      state_d   = S_BUS;
      req_d     = 1'b1;
      we_d      = is_write_q;
      be_d      = 4'hF;
      tmo_cnt_d = '0;
    end

    if (end_bus) begin
      state_d    = S_STAT;
      req_d      = 1'b0;
      we_d       = 1'b0;
      be_d       = 4'h0;
      tx_valid_d = 1'b1;
      tx_data_d  = end_status;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RES) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      byte_cnt_q <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tmo_cnt_q  <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tmo_cnt_q  <= tmo_cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign DATA_REQ   = req_q;
  assign DATA_WE    = we_q;
  assign DATA_BE    = be_q;
  assign DATA_ADDR  = addr_q;
  assign DATA_WDATA = wdata_q;
  assign TX_VALID   = tx_valid_q;
  assign TX_DATA    = tx_data_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_edusoc_dbg_master.sv
// Bench for edusoc_dbg_master: directed commands against a transaction-level model of
// the expected bus requests and response bytes, checked by a per-cycle monitor.
module tb_edusoc_dbg_master;

  localparam int unsigned TMO = 8;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RES;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        DATA_REQ;
  logic        DATA_VALID;
  logic        DATA_WE;
  logic [3:0]  DATA_BE;
  logic [31:0] DATA_ADDR;
  logic [31:0] DATA_WDATA;
  logic [31:0] DATA_RDATA;
  logic        BUSY;

  edusoc_dbg_master #(.TIMEOUT(TMO)) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RES    (CPU_RES),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .DATA_REQ   (DATA_REQ),
    .DATA_VALID (DATA_VALID),
    .DATA_WE    (DATA_WE),
    .DATA_BE    (DATA_BE),
    .DATA_ADDR  (DATA_ADDR),
    .DATA_WDATA (DATA_WDATA),
    .DATA_RDATA (DATA_RDATA),
    .BUSY       (BUSY)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int          n_pass;
  int          n_total;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_we;
  int          exp_req_n;
  int          exp_tx_n;
  int          resp_wait;
  logic [31:0] resp_rdata;
  bit          force_valid;
  bit          stall_mode;
  bit          mon_en;
  int          req_cycles;
  int          tx_count;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic        last_we;
  logic [7:0]  last_tx;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Responder answers resp_wait cycles after the request rises; negative means never.
  initial begin : responder
    int age;
    age = 0;
    DATA_VALID = 1'b0;
    DATA_RDATA = 32'h0;
    forever begin
      @(posedge CPU_CLK); #1;
      if (DATA_REQ === 1'b1) age++;
      else age = 0;
      DATA_VALID = force_valid || (age > 0 && resp_wait >= 0 && age == resp_wait + 1);
      DATA_RDATA = (age > 0) ? resp_rdata : 32'h0;
    end
  end

  initial begin : tx_sink
    int stall;
    stall = 0;
    TX_READY = 1'b1;
    forever begin
      @(posedge CPU_CLK); #1;
      if (stall_mode && TX_VALID === 1'b1 && stall < 5) begin
        TX_READY = 1'b0;
        stall++;
      end else begin
        TX_READY = 1'b1;
        stall = 0;
      end
    end
  end

  initial begin : monitor
    logic       prev_valid;
    logic       prev_ready;
    logic [7:0] prev_data;
    logic [7:0] want;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = 8'h00;
    req_cycles = 0;
    tx_count   = 0;
    forever begin
      @(negedge CPU_CLK);
      if (mon_en) begin
        if (DATA_REQ === 1'b1) begin
          req_cycles++;
          last_addr  = DATA_ADDR;
          last_wdata = DATA_WDATA;
          last_we    = DATA_WE;
          checkOutput("bus_addr", DATA_ADDR, exp_addr);
          checkOutput("bus_we", 32'(DATA_WE), 32'(exp_we));
          checkOutput("bus_be", 32'(DATA_BE), 32'hF);
          if (exp_we) checkOutput("bus_wdata", DATA_WDATA, exp_wdata);
        end else begin
          checkOutput("idle_be", 32'(DATA_BE), 32'h0);
        end
        if (TX_VALID === 1'b1 && prev_valid && !prev_ready)
          checkOutput("tx_stable", 32'(TX_DATA), 32'(prev_data));
        if (TX_VALID === 1'b1 && TX_READY === 1'b1) begin
          tx_count++;
          last_tx = TX_DATA;
          if (exp_tx.size() > 0) begin
            want = exp_tx.pop_front();
            checkOutput("tx_byte", 32'(TX_DATA), 32'(want));
          end else begin
            n_total++;
            $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no byte", TX_DATA);
          end
        end
        prev_valid = TX_VALID;
        prev_ready = TX_READY;
        prev_data  = TX_DATA;
      end
    end
  end

  // Transaction-level expectation: address word-aligned, status decided by whether the
  // responder answers within TMO request cycles, read data returned LSB first.
  task automatic model_cmd(input bit is_w, input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    exp_we    = is_w;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_wdata = wdata;
    ok        = (resp_wait >= 0) && (resp_wait < int'(TMO));
    exp_req_n = ok ? resp_wait + 1 : int'(TMO);
    if (!ok) exp_tx.push_back(8'h45);
    else begin
      exp_tx.push_back(8'h4B);
      if (!is_w) for (int k = 0; k < 4; k++) exp_tx.push_back(8'((resp_rdata >> (8 * k)) & 32'hFF));
    end
    exp_tx_n = exp_tx.size();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CPU_CLK); #1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
  endtask

  task automatic applyStimulus(input bit is_w, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(is_w ? 8'h57 : 8'h52);
    for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
    if (is_w) for (int k = 0; k < 4; k++) send_byte(wdata[8*k +: 8]);
    checkOutput("req_rise", 32'(DATA_REQ), 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    @(negedge CPU_CLK);
    while ((exp_tx.size() != 0 || BUSY !== 1'b0 || TX_VALID !== 1'b0) && n < budget) begin
      @(negedge CPU_CLK);
      n++;
    end
    if (n >= budget) begin
      n_total++;
      $display("[TB] FAIL %s_done: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic run_cmd(input string name, input bit is_w, input logic [31:0] addr,
                         input logic [31:0] wdata, output int req_n, output int tx_n);
    int rb;
    int tb;
    rb = req_cycles;
    tb = tx_count;
    model_cmd(is_w, addr, wdata);
    applyStimulus(is_w, addr, wdata);
    if (exp_req_n == 1) begin
      @(posedge CPU_CLK); #1;
      checkOutput({name, "_stat_valid"}, 32'(TX_VALID), 32'd1);
      checkOutput({name, "_stat_data"}, 32'(TX_DATA), 32'(exp_tx[0]));
      checkOutput({name, "_req_drop"}, 32'(DATA_REQ), 32'd0);
    end
    wait_done(name, 300);
    req_n = req_cycles - rb;
    tx_n  = tx_count - tb;
    checkOutput({name, "_req_cycles"}, 32'(req_n), 32'(exp_req_n));
    checkOutput({name, "_tx_count"}, 32'(tx_n), 32'(exp_tx_n));
  endtask

  task automatic check_reset_values(input string name);
    checkOutput({name, "_req"}, 32'(DATA_REQ), 32'd0);
    checkOutput({name, "_we"}, 32'(DATA_WE), 32'd0);
    checkOutput({name, "_be"}, 32'(DATA_BE), 32'd0);
    checkOutput({name, "_addr"}, DATA_ADDR, 32'd0);
    checkOutput({name, "_wdata"}, DATA_WDATA, 32'd0);
    checkOutput({name, "_tx_valid"}, 32'(TX_VALID), 32'd0);
    checkOutput({name, "_tx_data"}, 32'(TX_DATA), 32'd0);
    checkOutput({name, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int req_n;
    int tx_n;
    int rb;
    int tb;
    n_pass = 0;  n_total = 0;
    CPU_RES = 1'b1;  RX_DATA = 8'h00;  RX_VALID = 1'b0;
    resp_wait = 0;  resp_rdata = 32'h0;  force_valid = 1'b0;  stall_mode = 1'b0;
    mon_en = 1'b0;  exp_addr = 32'h0;  exp_wdata = 32'h0;  exp_we = 1'b0;
    exp_req_n = 0;  exp_tx_n = 0;

    repeat (3) @(posedge CPU_CLK);
    #1;
    check_reset_values("reset");
    CPU_RES = 1'b0;
    mon_en  = 1'b1;
    @(posedge CPU_CLK); #1;

    resp_wait = 1;
    run_cmd("wr_1wait", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, req_n, tx_n);
    checkOutput("wr_req_lit", 32'(req_n), 32'd2);
    checkOutput("wr_addr_lit", last_addr, 32'h0000_1000);
    checkOutput("wr_wdata_lit", last_wdata, 32'hDEAD_BEEF);
    checkOutput("wr_we_lit", 32'(last_we), 32'd1);
    checkOutput("wr_status_lit", 32'(last_tx), 32'h4B);

    resp_wait = 0;  resp_rdata = 32'h1234_5678;
    run_cmd("rd_0wait", 1'b0, 32'h0000_2007, 32'h0, req_n, tx_n);
    checkOutput("rd_addr_lit", last_addr, 32'h0000_2004);
    checkOutput("rd_we_lit", 32'(last_we), 32'd0);
    checkOutput("rd_tx_lit", 32'(tx_n), 32'd5);
    checkOutput("rd_last_lit", 32'(last_tx), 32'h12);

    resp_wait = -1;
    run_cmd("rd_timeout", 1'b0, 32'h0000_3000, 32'h0, req_n, tx_n);
    checkOutput("to_req_lit", 32'(req_n), 32'd8);
    checkOutput("to_tx_lit", 32'(tx_n), 32'd1);
    checkOutput("to_status_lit", 32'(last_tx), 32'h45);
    checkOutput("to_busy_low", 32'(BUSY), 32'd0);

    resp_wait = 7;  resp_rdata = 32'hCAFE_F00D;
    run_cmd("rd_edge", 1'b0, 32'h0000_3104, 32'h0, req_n, tx_n);
    checkOutput("edge_req_lit", 32'(req_n), 32'd8);
    checkOutput("edge_tx_lit", 32'(tx_n), 32'd5);
    checkOutput("edge_last_lit", 32'(last_tx), 32'hCA);

    // Slow sink; a would-be write command arrives while read data is still draining.
    resp_wait = 0;  resp_rdata = 32'hA1B2_C3D4;  stall_mode = 1'b1;
    rb = req_cycles;  tb = tx_count;
    model_cmd(1'b0, 32'h0000_4008, 32'h0);
    applyStimulus(1'b0, 32'h0000_4008, 32'h0);
    repeat (10) @(posedge CPU_CLK);
    #1;
    send_byte(8'h57);  send_byte(8'h11);  send_byte(8'h22);  send_byte(8'h33);  send_byte(8'h44);
    wait_done("rd_stall", 300);
    stall_mode = 1'b0;
    checkOutput("stall_req_lit", 32'(req_cycles - rb), 32'd1);
    checkOutput("stall_tx_lit", 32'(tx_count - tb), 32'd5);
    checkOutput("stall_last_lit", 32'(last_tx), 32'hA1);
    checkOutput("stall_busy_low", 32'(BUSY), 32'd0);

    rb = req_cycles;  tb = tx_count;
    send_byte(8'h00);
    @(negedge CPU_CLK);  force_valid = 1'b1;
    @(negedge CPU_CLK);  force_valid = 1'b0;
    repeat (3) @(negedge CPU_CLK);
    checkOutput("garbage_busy", 32'(BUSY), 32'd0);
    checkOutput("garbage_tx", 32'(TX_VALID), 32'd0);
    checkOutput("garbage_req", 32'(req_cycles - rb), 32'd0);
    checkOutput("garbage_tx_count", 32'(tx_count - tb), 32'd0);
    resp_wait = 0;
    run_cmd("wr_after_garbage", 1'b1, 32'h0000_0040, 32'h0BAD_F00D, req_n, tx_n);
    checkOutput("wag_addr_lit", last_addr, 32'h0000_0040);
    checkOutput("wag_status_lit", 32'(last_tx), 32'h4B);

    resp_wait = -1;  exp_we = 1'b0;  exp_addr = 32'h0000_5000;
    applyStimulus(1'b0, 32'h0000_5002, 32'h0);
    repeat (2) @(posedge CPU_CLK);
    #1;
    checkOutput("rst_req_before", 32'(DATA_REQ), 32'd1);
    CPU_RES = 1'b1;
    @(posedge CPU_CLK); #1;
    check_reset_values("mid_reset");
    CPU_RES = 1'b0;
    @(posedge CPU_CLK); #1;

    resp_wait = 0;  resp_rdata = 32'h0F1E_2D3C;
    run_cmd("rd_after_reset", 1'b0, 32'h0000_6010, 32'h0, req_n, tx_n);
    checkOutput("rar_addr_lit", last_addr, 32'h0000_6010);
    checkOutput("rar_tx_lit", 32'(tx_n), 32'd5);
    checkOutput("rar_last_lit", 32'(last_tx), 32'h0F);

    repeat (2) @(posedge CPU_CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
